// File: rtl/mandelbrot_dispatcher_if.sv
// Engine-farm bus for the Mandelbrot dispatcher: pixel grant channel, per-engine
// result collection channel and the single valid/ready output stream.
// master = dispatcher side, slave = engines + pixel writer side.
interface mandelbrot_dispatcher_if #(
  parameter int N   = 4,
  parameter int PDW = 10,
  parameter int IW  = 6
);
  logic [N-1:0]     eng_req;
  logic [N-1:0]     eng_grant;
  logic [PDW-1:0]   eng_x0;
  logic [PDW-1:0]   eng_y0;
  logic [N-1:0]     eng_res_valid;
  logic [N*PDW-1:0] eng_res_x;
  logic [N*PDW-1:0] eng_res_y;
  logic [N*IW-1:0]  eng_res_iter;
  logic [N-1:0]     eng_res_ack;
  logic             out_valid;
  logic             out_ready;
  logic [PDW-1:0]   out_x;
  logic [PDW-1:0]   out_y;
  logic [IW-1:0]    out_iter;

  modport master (
    input  eng_req, eng_res_valid, eng_res_x, eng_res_y, eng_res_iter, out_ready,
    output eng_grant, eng_x0, eng_y0, eng_res_ack, out_valid, out_x, out_y, out_iter
  );

  modport slave (
    output eng_req, eng_res_valid, eng_res_x, eng_res_y, eng_res_iter, out_ready,
    input  eng_grant, eng_x0, eng_y0, eng_res_ack, out_valid, out_x, out_y, out_iter
  );
endinterface

// File: rtl/mandelbrot_dispatcher.sv
// Frame scheduler for a farm of Mandelbrot engines: raster-scans the screen handing
// one pixel per cycle to a requesting engine (round-robin), collects results
// round-robin into one valid/ready stream, and pulses frame_done at end of frame.
// Optional feature macro: DISPATCH_PERF_EN (per-frame busy-cycle counter on frame_cycles).
module mandelbrot_dispatcher #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int ITERATIONS_WIDTH = 6,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  mandelbrot_dispatcher_if.master  bus,
  output logic                     busy,
  output logic                     frame_done,
  output logic [31:0]              frame_cycles
);
  localparam int N   = NUM_ENGINES;
  localparam int PDW = PIXEL_DATA_WIDTH;
  localparam int IW  = ITERATIONS_WIDTH;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int OW  = $clog2(N + 1) + 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [PDW-1:0] x_q, x_d, y_q, y_d;
  logic [PW-1:0]  grant_ptr_q, grant_ptr_d, ack_ptr_q, ack_ptr_d;
  logic [OW-1:0]  outstanding_q, outstanding_d;
  logic           out_valid_q, out_valid_d;
  logic [PDW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic [IW-1:0]  out_iter_q, out_iter_d;

  logic [N-1:0]   grant, ack;
  logic           grant_any, ack_any, out_free;
  logic [PW-1:0]  grant_idx, ack_idx;
  int             arb_idx_g, arb_idx_a;

  logic [PDW-1:0] res_x_arr    [N];
  logic [PDW-1:0] res_y_arr    [N];
  logic [IW-1:0]  res_iter_arr [N];

  // Unpack the flat per-engine result buses into arrays indexed by engine.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign res_x_arr[gi]    = bus.eng_res_x[gi*PDW +: PDW];
    assign res_y_arr[gi]    = bus.eng_res_y[gi*PDW +: PDW];
    assign res_iter_arr[gi] = bus.eng_res_iter[gi*IW +: IW];
  end

  // The output register can take a new result when empty or being drained this cycle.
  assign out_free = (!out_valid_q || bus.out_ready) && !reset;

  // Round-robin pixel grant among requesting engines, only while dispatching.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx_g = 0;
    for (int k = 0; k < N; k++) begin
      arb_idx_g = int'(grant_ptr_q) + k;
      if (arb_idx_g >= N) arb_idx_g = arb_idx_g - N;
      if (!grant_any && state_q == DISPATCH && bus.eng_req[arb_idx_g]) begin
        grant_any        = 1'b1;
        grant_idx        = PW'(arb_idx_g);
        grant[arb_idx_g] = 1'b1;
      end
    end
  end

  // Round-robin result ack among valid engines, whenever the output register is free.
  always_comb begin
    ack       = '0;
    ack_any   = 1'b0;
    ack_idx   = '0;
    arb_idx_a = 0;
    for (int k = 0; k < N; k++) begin
      arb_idx_a = int'(ack_ptr_q) + k;
      if (arb_idx_a >= N) arb_idx_a = arb_idx_a - N;
      if (!ack_any && out_free && bus.eng_res_valid[arb_idx_a]) begin
        ack_any        = 1'b1;
        ack_idx        = PW'(arb_idx_a);
        ack[arb_idx_a] = 1'b1;
      end
    end
  end

  // Next-state logic: frame FSM, raster counters, output register, outstanding count.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    grant_ptr_d   = grant_ptr_q;
    ack_ptr_d     = ack_ptr_q;
    outstanding_d = outstanding_q;
    out_valid_d   = out_valid_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    out_iter_d    = out_iter_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DISPATCH;
          x_d     = '0;
          y_d     = '0;
        end
      end
      DISPATCH: begin
        if (grant_any) begin
          grant_ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
          if (x_q == PDW'(SCREEN_WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (y_q == PDW'(SCREEN_HEIGHT - 1)) state_d = DRAIN;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (outstanding_q == '0 && !out_valid_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (out_free) begin
      out_valid_d = ack_any;
      if (ack_any) begin
        out_x_d    = res_x_arr[ack_idx];
        out_y_d    = res_y_arr[ack_idx];
        out_iter_d = res_iter_arr[ack_idx];
        ack_ptr_d  = (ack_idx == PW'(N - 1)) ? '0 : ack_idx + 1'b1;
      end
    end

    // Stray acks with nothing outstanding must not wrap the count below zero.
    if (grant_any && !ack_any) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (ack_any && !grant_any && outstanding_q != '0) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      grant_ptr_q   <= '0;
      ack_ptr_q     <= '0;
      outstanding_q <= '0;
      out_valid_q   <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_iter_q    <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      grant_ptr_q   <= grant_ptr_d;
      ack_ptr_q     <= ack_ptr_d;
      outstanding_q <= outstanding_d;
      out_valid_q   <= out_valid_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_iter_q    <= out_iter_d;
    end
  end

  assign bus.eng_grant   = grant;
  assign bus.eng_res_ack = ack;
  assign bus.eng_x0      = x_q;
  assign bus.eng_y0      = y_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_x       = out_x_q;
  assign bus.out_y       = out_y_q;
  assign bus.out_iter    = out_iter_q;
  assign busy            = (state_q == DISPATCH) || (state_q == DRAIN);
  assign frame_done      = (state_q == DONE);

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d, frame_cycles_q, frame_cycles_d;

  // Busy-cycle counter: cleared on start, saturating; captured on frame_done.
  always_comb begin
    perf_cnt_d     = perf_cnt_q;
    frame_cycles_d = frame_cycles_q;
    if (state_q == IDLE && start) begin
      perf_cnt_d = '0;
    end else if (busy && perf_cnt_q != '1) begin
      perf_cnt_d = perf_cnt_q + 1'b1;
    end
    if (state_q == DONE) frame_cycles_d = perf_cnt_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt_q     <= '0;
      frame_cycles_q <= '0;
    end else begin
      perf_cnt_q     <= perf_cnt_d;
      frame_cycles_q <= frame_cycles_d;
    end
  end

  assign frame_cycles = frame_cycles_q;
`else
  assign frame_cycles = '0;
`endif
endmodule

// File: tb/tb_mandelbrot_dispatcher.sv
// Directed bench for mandelbrot_dispatcher: a 1-engine 4x2 instance and a
// 4-engine 640x8 instance, each exercised by one task per scenario.
module tb_mandelbrot_dispatcher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, start4;
  logic        busy1, busy4, fd1, fd4;
  logic [31:0] fc1, fc4;
  int          tests = 0;
  int          fails = 0;

  mandelbrot_dispatcher_if #(.N(1), .PDW(10), .IW(6)) if1 ();
  mandelbrot_dispatcher_if #(.N(4), .PDW(10), .IW(6)) if4 ();

  mandelbrot_dispatcher #(
    .NUM_ENGINES(1), .PIXEL_DATA_WIDTH(10), .ITERATIONS_WIDTH(6),
    .SCREEN_WIDTH(4), .SCREEN_HEIGHT(2)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(if1),
    .busy(busy1), .frame_done(fd1), .frame_cycles(fc1)
  );

  mandelbrot_dispatcher #(
    .NUM_ENGINES(4), .PIXEL_DATA_WIDTH(10), .ITERATIONS_WIDTH(6),
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(8)
  ) dut4 (
    .clk(clk), .reset(reset), .start(start4), .bus(if4),
    .busy(busy4), .frame_done(fd4), .frame_cycles(fc4)
  );

  typedef struct {
    int x;
    int y;
    int rdy;
  } pend_t;

  task automatic idle_inputs();
    start1 = 1'b0; start4 = 1'b0;
    if1.eng_req = '0; if1.eng_res_valid = '0; if1.eng_res_x = '0;
    if1.eng_res_y = '0; if1.eng_res_iter = '0; if1.out_ready = 1'b1;
    if4.eng_req = '0; if4.eng_res_valid = '0; if4.eng_res_x = '0;
    if4.eng_res_y = '0; if4.eng_res_iter = '0; if4.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if4.eng_req = 4'hF;
    #1;
    tests++;
    if (if4.eng_grant !== 4'b0000 || busy4 !== 1'b0 || fd4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl4: grant=%b busy=%b done=%b, required 0000/0/0", if4.eng_grant, busy4, fd4);
    end
    tests++;
    if (if4.eng_x0 !== 10'd0 || if4.eng_y0 !== 10'd0 || if4.out_valid !== 1'b0 || if4.out_x !== 10'd0) begin
      fails++;
      $display("FAIL reset_data4: x0=%0d y0=%0d ov=%b ox=%0d, required 0/0/0/0", if4.eng_x0, if4.eng_y0, if4.out_valid, if4.out_x);
    end
    tests++;
    if (busy1 !== 1'b0 || if1.eng_res_ack !== 1'b0 || if1.out_iter !== 6'd0 || fc1 !== 32'd0 || fc4 !== 32'd0) begin
      fails++;
      $display("FAIL reset_misc: busy1=%b ack1=%b iter1=%0d fc1=%0d fc4=%0d, required all 0", busy1, if1.eng_res_ack, if1.out_iter, fc1, fc4);
    end
    $display("[TB] reset: state checked");
    if4.eng_req = 4'h0;
  endtask

  // N=1, 4x2 screen, engine returns iter=x+y three cycles after the grant.
  task automatic test_single_engine();
    pend_t q[$];
    int nout = 0, ndone = 0, nbusy = 0, done_cyc = -1;
    int ex, ey;
    logic [31:0] exp_fc;
    do_reset();
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      start1 = (cyc == 0);
      if1.eng_req = 1'b1;
      if (q.size() > 0 && q[0].rdy <= cyc) begin
        if1.eng_res_valid = 1'b1;
        if1.eng_res_x = 10'(q[0].x);
        if1.eng_res_y = 10'(q[0].y);
        if1.eng_res_iter = 6'(q[0].x + q[0].y);
      end else begin
        if1.eng_res_valid = 1'b0;
      end
      #1;
      if (busy1) nbusy++;
      if (fd1) begin
        ndone++;
        done_cyc = cyc;
      end
      if (if1.out_valid && if1.out_ready) begin
        ex = nout % 4;
        ey = nout / 4;
        tests++;
        if (if1.out_x !== 10'(ex) || if1.out_y !== 10'(ey) || if1.out_iter !== 6'(ex + ey)) begin
          fails++;
          $display("FAIL single_out%0d: got (%0d,%0d,%0d), required (%0d,%0d,%0d)", nout, if1.out_x, if1.out_y, if1.out_iter, ex, ey, ex + ey);
        end else begin
          $display("[TB] single: out %0d = (%0d,%0d) iter %0d", nout, ex, ey, ex + ey);
        end
        nout++;
      end
      if (if1.eng_grant[0]) q.push_back('{int'(if1.eng_x0), int'(if1.eng_y0), cyc + 3});
      if (if1.eng_res_ack[0]) void'(q.pop_front());
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;
    end
    if1.eng_req = 1'b0;
    if1.eng_res_valid = 1'b0;
    tests++;
    if (nout != 8 || ndone != 1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL single_frame: outputs=%0d done_pulses=%0d busy=%b, required 8/1/0", nout, ndone, busy1);
    end
    tests++;
    if (nbusy != 13) begin
      fails++;
      $display("FAIL single_busy_cycles: got %0d, required 13", nbusy);
    end
`ifdef DISPATCH_PERF_EN
    exp_fc = 32'(nbusy);
`else
    exp_fc = 32'd0;
`endif
    tests++;
    if (fc1 !== exp_fc) begin
      fails++;
      $display("FAIL single_frame_cycles: got %0d, required %0d", fc1, exp_fc);
    end
  endtask

  // All four engines request: grants rotate 0..3 with raster x advancing.
  task automatic test_grant_rr();
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    if4.eng_req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (if4.eng_grant !== exp_g[i] || if4.eng_x0 !== 10'(i) || if4.eng_y0 !== 10'd0) begin
        fails++;
        $display("FAIL grant_rr%0d: grant=%b (%0d,%0d), required %b (%0d,0)", i, if4.eng_grant, if4.eng_x0, if4.eng_y0, exp_g[i], i);
      end else begin
        $display("[TB] grant_rr: grant %b at (%0d,0)", exp_g[i], i);
      end
      @(negedge clk);
    end
    if4.eng_req = 4'h0;
  endtask

  // Engines 1 and 3 valid together: acked 1 then 3, pointer back to 0.
  task automatic test_ack_rr();
    do_reset();
    if4.eng_res_x = '0;
    if4.eng_res_x[10 +: 10] = 10'd11;
    if4.eng_res_x[30 +: 10] = 10'd33;
    if4.eng_res_valid = 4'b1010;
    #1;
    tests++;
    if (if4.eng_res_ack !== 4'b0010) begin
      fails++;
      $display("FAIL ack_rr_first: ack=%b, required 0010", if4.eng_res_ack);
    end
    @(negedge clk);
    if4.eng_res_valid = 4'b1000;
    #1;
    tests++;
    if (if4.eng_res_ack !== 4'b1000 || if4.out_valid !== 1'b1 || if4.out_x !== 10'd11) begin
      fails++;
      $display("FAIL ack_rr_second: ack=%b ov=%b ox=%0d, required 1000/1/11", if4.eng_res_ack, if4.out_valid, if4.out_x);
    end
    @(negedge clk);
    if4.eng_res_valid = 4'b0000;
    #1;
    tests++;
    if (if4.out_valid !== 1'b1 || if4.out_x !== 10'd33) begin
      fails++;
      $display("FAIL ack_rr_out3: ov=%b ox=%0d, required 1/33", if4.out_valid, if4.out_x);
    end
    @(negedge clk);
    if4.eng_res_valid = 4'b1111;
    #1;
    tests++;
    if (if4.eng_res_ack !== 4'b0001) begin
      fails++;
      $display("FAIL ack_rr_ptr: ack=%b, required 0001", if4.eng_res_ack);
    end
    $display("[TB] ack_rr: sequence 0010,1000 then 0001");
    @(negedge clk);
    if4.eng_res_valid = 4'b0000;
  endtask

  // Output stalled for 10 cycles with results pending, then released.
  task automatic test_backpressure();
    int stall_bad = 0;
    do_reset();
    if4.out_ready = 1'b0;
    if4.eng_res_x = {10'd9, 10'd9, 10'd7, 10'd5};
    if4.eng_res_y = {10'd3, 10'd3, 10'd2, 10'd1};
    if4.eng_res_iter = {6'd4, 6'd12, 6'd9, 6'd2};
    if4.eng_res_valid = 4'b0001;
    #1;
    tests++;
    if (if4.eng_res_ack !== 4'b0001) begin
      fails++;
      $display("FAIL bp_load: ack=%b, required 0001", if4.eng_res_ack);
    end
    @(negedge clk);
    if4.eng_res_valid = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++;
      if (if4.eng_res_ack !== 4'b0000 || if4.out_valid !== 1'b1 || if4.out_x !== 10'd5 ||
          if4.out_y !== 10'd1 || if4.out_iter !== 6'd2) begin
        fails++;
        stall_bad++;
        $display("FAIL bp_stall%0d: ack=%b ov=%b out=(%0d,%0d,%0d), required 0000/1/(5,1,2)", i, if4.eng_res_ack, if4.out_valid, if4.out_x, if4.out_y, if4.out_iter);
      end
      @(negedge clk);
    end
    $display("[TB] backpressure: 10 stalled cycles, %0d bad", stall_bad);
    if4.out_ready = 1'b1;
    #1;
    tests++;
    if (if4.eng_res_ack !== 4'b0010 || if4.out_x !== 10'd5) begin
      fails++;
      $display("FAIL bp_release0: ack=%b ox=%0d, required 0010/5", if4.eng_res_ack, if4.out_x);
    end
    @(negedge clk);
    if4.eng_res_valid = 4'b0100;
    #1;
    tests++;
    if (if4.eng_res_ack !== 4'b0100 || if4.out_valid !== 1'b1 || if4.out_x !== 10'd7 || if4.out_iter !== 6'd9) begin
      fails++;
      $display("FAIL bp_release1: ack=%b ov=%b ox=%0d it=%0d, required 0100/1/7/9", if4.eng_res_ack, if4.out_valid, if4.out_x, if4.out_iter);
    end
    @(negedge clk);
    if4.eng_res_valid = 4'b0000;
    #1;
    tests++;
    if (if4.out_valid !== 1'b1 || if4.out_x !== 10'd9 || if4.out_iter !== 6'd12) begin
      fails++;
      $display("FAIL bp_release2: ov=%b ox=%0d it=%0d, required 1/9/12", if4.out_valid, if4.out_x, if4.out_iter);
    end
    @(negedge clk);
    #1;
    tests++;
    if (if4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: ov=%b, required 0", if4.out_valid);
    end
  endtask

  // Line wrap at x=639 and end-of-frame at (639,7) on the 640x8 instance.
  task automatic test_raster_wrap();
    bit check_next = 1'b0;
    bit last_seen = 1'b0;
    int ngr = 0;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start4 = (c == 0);
      if4.eng_req = 4'hF;
      #1;
      if (check_next) begin
        check_next = 1'b0;
        tests++;
        if (if4.eng_x0 !== 10'd0 || if4.eng_y0 !== 10'd6) begin
          fails++;
          $display("FAIL wrap_line: offered (%0d,%0d), required (0,6)", if4.eng_x0, if4.eng_y0);
        end else begin
          $display("[TB] wrap: (639,5) -> (0,6)");
        end
      end
      if (|if4.eng_grant) begin
        ngr++;
        if (if4.eng_x0 == 10'd639 && if4.eng_y0 == 10'd5) check_next = 1'b1;
        if (if4.eng_x0 == 10'd639 && if4.eng_y0 == 10'd7) begin
          last_seen = 1'b1;
          break;
        end
      end
    end
    tests++;
    if (!last_seen || ngr != 5120) begin
      fails++;
      $display("FAIL wrap_last: last_seen=%0d grants=%0d, required 1/5120", last_seen, ngr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if (if4.eng_grant !== 4'b0000 || (i == 0 && busy4 !== 1'b1)) begin
        fails++;
        $display("FAIL wrap_drain%0d: grant=%b busy=%b, required 0000 (busy 1 first cycle)", i, if4.eng_grant, busy4);
      end
    end
    $display("[TB] wrap: frame of %0d grants ended, grants stopped", ngr);
    if4.eng_req = 4'h0;
    start4 = 1'b0;
  endtask

  // Asynchronous reset mid-dispatch, then a fresh frame starts at (0,0).
  task automatic test_reset_mid_frame();
    do_reset();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    if4.eng_req = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (if4.eng_grant !== 4'b0000 || busy4 !== 1'b0 || if4.eng_x0 !== 10'd0 ||
        if4.eng_y0 !== 10'd0 || if4.out_valid !== 1'b0 || fd4 !== 1'b0) begin
      fails++;
      $display("FAIL midreset: grant=%b busy=%b (%0d,%0d) ov=%b done=%b, required all 0", if4.eng_grant, busy4, if4.eng_x0, if4.eng_y0, if4.out_valid, fd4);
    end
    @(negedge clk);
    reset = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    #1;
    tests++;
    if (if4.eng_grant !== 4'b0001 || if4.eng_x0 !== 10'd0 || if4.eng_y0 !== 10'd0) begin
      fails++;
      $display("FAIL midreset_restart: grant=%b (%0d,%0d), required 0001 (0,0)", if4.eng_grant, if4.eng_x0, if4.eng_y0);
    end
    $display("[TB] midreset: outputs cleared, frame restarted");
    if4.eng_req = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_engine();
    test_grant_rr();
    test_ack_rr();
    test_backpressure();
    test_raster_wrap();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
